// File: rtl/dma_cmd_splitter.sv
// dma_cmd_splitter: breaks a {length, address} DMA command into sub-commands that never cross a 2^BOUNDARY_LOG2 byte boundary.
// Latency: first sub-command valid one cycle after acceptance, then one sub-command per cycle; one idle cycle between parents.
// Backpressure: sub-command held stable while m_axis_cmd_tready is low; s_axis_cmd_tready is low for the whole split.
module dma_cmd_splitter #(
  parameter int BOUNDARY_LOG2 = 12
) (
  input  logic        net_clk,
  input  logic        net_areset,
  input  logic        s_axis_cmd_tvalid,
  output logic        s_axis_cmd_tready,
  input  logic [95:0] s_axis_cmd_tdata,
  output logic        m_axis_cmd_tvalid,
  input  logic        m_axis_cmd_tready,
  output logic [95:0] m_axis_cmd_tdata,
  output logic        m_axis_cmd_tlast,
  output logic        busy,
  output logic [31:0] subcmd_count
);

  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_SPLIT = 1'b1;
  // Boundary is at most 64 KiB, so the room to the next boundary fits a 32-bit length.
  localparam logic [31:0] BOUNDARY_BYTES = 32'd1 << BOUNDARY_LOG2;

  logic [0:0]  r_state;
  logic [63:0] r_addr;
  logic [31:0] r_rem;
  logic [31:0] r_count;
  // Keeps upstream ready low until the first clock edge after reset release.
  logic        r_rdy_en;

  logic [31:0] w_room;
  logic [31:0] w_chunk;
  logic        w_last;
  logic        w_split;
  logic        w_accept;
  logic        w_m_hs;
  logic [63:0] w_in_addr;
  logic [31:0] w_in_len;

  assign w_in_addr = s_axis_cmd_tdata[63:0];
  assign w_in_len  = s_axis_cmd_tdata[95:64];
  assign w_split   = (r_state == ST_SPLIT);

  // Chunk is whatever is left, clipped at the next boundary; never zero because
  // remaining is non-zero in SPLIT and room is at least one byte.
  always_comb begin
    w_room  = BOUNDARY_BYTES - 32'(r_addr[BOUNDARY_LOG2-1:0]);
    w_chunk = (r_rem < w_room) ? r_rem : w_room;
    w_last  = (w_chunk == r_rem);
  end

  assign s_axis_cmd_tready = r_rdy_en & ~w_split;
  assign w_accept          = s_axis_cmd_tvalid & s_axis_cmd_tready;

  // Outputs come only from registered state, so nothing on s_axis reaches m_axis combinationally.
  assign busy              = w_split;
  assign m_axis_cmd_tvalid = w_split;
  assign m_axis_cmd_tdata  = w_split ? {w_chunk, r_addr} : 96'd0;
  assign m_axis_cmd_tlast  = w_split & w_last;
  assign w_m_hs            = m_axis_cmd_tvalid & m_axis_cmd_tready;
  assign subcmd_count      = r_count;

  // Ready enable: cleared by reset, set on the first edge afterwards.
  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  // Split FSM: capture a non-empty command, then walk it one chunk per handshake.
  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      r_state <= ST_IDLE;
      r_addr  <= 64'd0;
      r_rem   <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Zero-length commands are accepted and dropped.
          if (w_accept && (w_in_len != 32'd0)) begin
            r_addr  <= w_in_addr;
            r_rem   <= w_in_len;
            r_state <= ST_SPLIT;
          end
        end
        default: begin
          if (w_m_hs) begin
            r_addr <= r_addr + 64'(w_chunk);
            r_rem  <= r_rem - w_chunk;
            if (w_last) begin
              r_state <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

  // Sub-command counter, free-running modulo 2^32.
  always_ff @(posedge net_clk or posedge net_areset) begin
    if (net_areset) begin
      r_count <= 32'd0;
    end else if (w_m_hs) begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule

// File: doc/dma_cmd_splitter.md
DMA_CMD_SPLITTER -- requirements
Module: dma_cmd_splitter

Interface
REQ-001 SHALL have parameter BOUNDARY_LOG2, default 12: split boundary is 2^BOUNDARY_LOG2 bytes (4 KiB); legal range 6..16.
REQ-002 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-003 SHALL have port net_clk, input, 1 bit: sole clock; all state on its rising edge.
REQ-004 SHALL have port net_areset, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port s_axis_cmd_tvalid, input, 1 bit: upstream DMA command valid.
REQ-006 SHALL have port s_axis_cmd_tready, output, 1 bit: command accepted when tvalid and tready are both high.
REQ-007 SHALL have port s_axis_cmd_tdata, input, 96 bits: [63:0] byte address, [95:64] byte length.
REQ-008 SHALL have port m_axis_cmd_tvalid, output, 1 bit: sub-command valid toward DMA engine.
REQ-009 SHALL have port m_axis_cmd_tready, input, 1 bit: DMA engine ready.
REQ-010 SHALL have port m_axis_cmd_tdata, output, 96 bits: same layout as s_axis_cmd_tdata.
REQ-011 SHALL have port m_axis_cmd_tlast, output, 1 bit: marks the final sub-command of a parent command.
REQ-012 SHALL have port busy, output, 1 bit: high while in SPLIT.
REQ-013 SHALL have port subcmd_count, output, 32 bits: count of sub-commands handed off since reset.

Function
REQ-014 SHALL implement FSM states IDLE and SPLIT.
REQ-015 In IDLE, s_axis_cmd_tready SHALL be 1 and m_axis_cmd_tvalid SHALL be 0; in SPLIT, s_axis_cmd_tready SHALL be 0.
REQ-016 On acceptance with length > 0, SHALL capture cur_addr=address and remaining=length, then enter SPLIT; the first sub-command is valid the next cycle (latency 1).
REQ-017 On acceptance with length 0, SHALL discard the command, stay in IDLE, emit nothing, and leave subcmd_count unchanged.
REQ-018 In SPLIT, m_axis_cmd_tvalid SHALL be 1 with tdata = {chunk, cur_addr}, where chunk = min(remaining, 2^BOUNDARY_LOG2 - cur_addr[BOUNDARY_LOG2-1:0]).
REQ-019 No sub-command SHALL cross a 2^BOUNDARY_LOG2 address boundary, and every chunk SHALL be >= 1.
REQ-020 m_axis_cmd_tlast SHALL be 1 exactly when chunk == remaining, and 0 whenever m_axis_cmd_tvalid is 0.
REQ-021 On an m-side handshake: cur_addr += chunk (modulo 2^64), remaining -= chunk, subcmd_count += 1 (wraps modulo 2^32).
REQ-022 On the handshake carrying tlast, SHALL return to IDLE; s_axis_cmd_tready is high the following cycle.
REQ-023 While m_axis_cmd_tvalid is high and m_axis_cmd_tready is low, m_axis_cmd_tdata and m_axis_cmd_tlast SHALL hold stable.
REQ-024 Throughput SHALL be one sub-command per cycle when m_axis_cmd_tready is held high, with one IDLE cycle between parent commands.
REQ-025 Output tdata/tlast SHALL derive only from registered state; there SHALL be no combinational path from s_axis_* to m_axis_*.

Reset
REQ-026 While net_areset is high, the FSM SHALL be IDLE, and m_axis_cmd_tvalid=0, m_axis_cmd_tlast=0, m_axis_cmd_tdata=0, busy=0, subcmd_count=0, cur_addr=0, remaining=0.
REQ-027 s_axis_cmd_tready SHALL be 0 while net_areset is high, and 1 from the first clock edge after release.
REQ-028 Reset asserted mid-SPLIT SHALL abandon the in-flight command immediately; no remaining sub-commands are emitted after release.

Verification
REQ-029 Scenario: addr 0x1000, len 0x2000 -> {addr 0x1000, len 0x1000, last 0}, then {addr 0x2000, len 0x1000, last 1}; subcmd_count=2.
REQ-030 Scenario: addr 0x0F00, len 0x300 -> {addr 0x0F00, len 0x100, last 0}, then {addr 0x1000, len 0x200, last 1}.
REQ-031 Scenario: addr 0x40, len 0 -> no m-side valid; tready stays 1; subcmd_count unchanged.
REQ-032 Scenario: addr 0xFFFFFFFFFFFFFF80, len 0x100 -> {addr 0xFFFFFFFFFFFFFF80, len 0x80}, then {addr 0x0, len 0x80, last 1} (address wrap).
REQ-033 Scenario: m_axis_cmd_tready held low 5 cycles during SPLIT -> tdata/tlast unchanged all 5 cycles; count increments only on handshake.
REQ-034 Scenario: net_areset pulsed during the second sub-command of addr 0x0, len 0x3000 -> outputs at reset values; no sub-commands after release; tready=1.
